mem_access: RTL and testbench

- Memory stage directly downstream of the execute stage.
- Consumes the execute pipeline registers (Z, Rt, IR, HI, LO) and runs the data-memory transaction for load/store instructions through a req/ack handshake. While that transaction is pending it raises a stall to the hazard controller.
- Presents the MEM/WB pipeline register (Z, load data, IR, HI, LO) to write-back.

---
 rtl/mem_access.sv | 207 ++++++++++++++++++++
 tb/tb_mem_access.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// mem_access: memory stage between execute and write-back. Runs the dmem
// req/ack transaction for loads/stores and holds the MEM/WB pipeline register.
//
// state  | meaning
// S_IDLE | no transaction; an aligned load/store raises req and stall here
// S_WAIT | req held, waiting for ack or for the timeout counter to expire
// S_DONE | access finished; result buffered until the next FLOW/ZERO edge
module mem_access #(
  parameter int          TIMEOUT   = 16,
  parameter logic [31:0] IR_BUBBLE = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ex_z,
  input  logic [31:0] ex_rt,
  input  logic [31:0] ex_ir,
  input  logic [31:0] ex_hi,
  input  logic [31:0] ex_lo,
  input  logic [1:0]  condition,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        mem_stall,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] reg_Z,
  output logic [31:0] reg_D,
  output logic [31:0] reg_IR,
  output logic [31:0] reg_HI,
  output logic [31:0] reg_LO
);

  localparam logic [1:0] COND_FLOW  = 2'b00;
  localparam logic [1:0] COND_STALL = 2'b01;
  localparam logic [1:0] COND_ZERO  = 2'b10;

  localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [31:0]   ld_buf;
  logic          fault;

  logic        is_load, is_store, is_signed;
  logic        sz_byte, sz_half, sz_word;
  logic        mem_op, misal, go;
  logic [31:0] lane, ld_data;
  logic [3:0]  be_c;
  logic        req_c, stall_c, timeout_c, retire;

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_signed = 1'b0;
    sz_byte   = 1'b0;
    sz_half   = 1'b0;
    sz_word   = 1'b0;
    case (ex_ir[31:26])
      6'h20: begin is_load  = 1'b1; sz_byte = 1'b1; is_signed = 1'b1; end
      6'h21: begin is_load  = 1'b1; sz_half = 1'b1; is_signed = 1'b1; end
      6'h23: begin is_load  = 1'b1; sz_word = 1'b1; end
      6'h24: begin is_load  = 1'b1; sz_byte = 1'b1; end
      6'h25: begin is_load  = 1'b1; sz_half = 1'b1; end
      6'h28: begin is_store = 1'b1; sz_byte = 1'b1; end
      6'h29: begin is_store = 1'b1; sz_half = 1'b1; end
      6'h2B: begin is_store = 1'b1; sz_word = 1'b1; end
      default: ;
    endcase
  end

  assign mem_op = is_load | is_store;
  assign misal  = mem_op & ((sz_half & ex_z[0]) | (sz_word & (ex_z[1:0] != 2'b00)));
  assign go     = mem_op & ~misal;

  // Little-endian: the addressed byte lane is shifted down to bit 0.
  assign lane = dmem_rdata >> {ex_z[1:0], 3'b000};

  always_comb begin
    ld_data    = lane;
    be_c       = 4'b1111;
    dmem_wdata = ex_rt;
    if (sz_byte) begin
      ld_data    = {{24{is_signed & lane[7]}}, lane[7:0]};
      be_c       = 4'b0001 << ex_z[1:0];
      dmem_wdata = {4{ex_rt[7:0]}};
    end else if (sz_half) begin
      ld_data    = {{16{is_signed & lane[15]}}, lane[15:0]};
      be_c       = ex_z[1] ? 4'b1100 : 4'b0011;
      dmem_wdata = {2{ex_rt[15:0]}};
    end
  end

  always_comb begin
    state_nxt = state;
    req_c     = 1'b0;
    stall_c   = 1'b0;
    timeout_c = 1'b0;
    case (state)
      S_IDLE: begin
        if (go) begin
          req_c     = 1'b1;
          stall_c   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (dmem_ack) begin
          state_nxt = S_DONE;
        end else if (cnt == '0) begin
          timeout_c = 1'b1;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        case (condition)
          COND_FLOW, COND_ZERO: state_nxt = S_IDLE;
          COND_STALL:           state_nxt = S_DONE;
          default:              state_nxt = S_DONE;
        endcase
      end
      default: state_nxt = S_IDLE;
    endcase
    // A squash wins over everything, including a timeout on the same edge.
    if (condition == COND_ZERO) begin
      state_nxt = S_IDLE;
      timeout_c = 1'b0;
    end
  end

  // Reset must silence the bus even while an aligned op sits on the inputs.
  assign dmem_req  = req_c & ~rst;
  assign mem_stall = stall_c & ~rst;
  assign dmem_we   = dmem_req & is_store;
  assign dmem_be   = dmem_req ? be_c : 4'b0000;
  assign dmem_addr = {ex_z[31:2], 2'b00};

  assign retire = (condition == COND_FLOW) &
                  ((state == S_DONE) | ((state == S_IDLE) & ~go));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      ld_buf  <= '0;
      fault   <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      bus_err <= timeout_c;
      if ((state == S_WAIT) && (state_nxt == S_WAIT))
        cnt <= cnt - CW'(1);
      else
        cnt <= CNT_LOAD;
      if ((state == S_WAIT) && dmem_ack) begin
        ld_buf <= is_load ? ld_data : '0;
        fault  <= 1'b0;
      end else if (timeout_c) begin
        ld_buf <= '0;
        fault  <= 1'b1;
      end else if (state == S_IDLE) begin
        fault <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_Z    <= '0;
      reg_D    <= '0;
      reg_IR   <= IR_BUBBLE;
      reg_HI   <= '0;
      reg_LO   <= '0;
      misalign <= 1'b0;
    end else begin
      misalign <= 1'b0;
      if (condition == COND_ZERO) begin
        reg_Z  <= '0;
        reg_D  <= '0;
        reg_IR <= IR_BUBBLE;
        reg_HI <= '0;
        reg_LO <= '0;
      end else if (retire) begin
        reg_Z  <= ex_z;
        reg_HI <= ex_hi;
        reg_LO <= ex_lo;
        if (state == S_DONE) begin
          reg_D  <= ld_buf;
          reg_IR <= fault ? IR_BUBBLE : ex_ir;
        end else begin
          reg_D    <= '0;
          reg_IR   <= misal ? IR_BUBBLE : ex_ir;
          misalign <= misal;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed vector table, squash/reset corner sequences,
// then random ops checked against a byte-lane arithmetic reference model.
module tb_mem_access;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] BUB     = 32'h0000_0000;
  localparam logic [1:0]  C_FLOW  = 2'b00;
  localparam logic [1:0]  C_STALL = 2'b01;
  localparam logic [1:0]  C_ZERO  = 2'b10;

  localparam logic [31:0] I_LB  = {6'h20, 26'h0430003};
  localparam logic [31:0] I_LH  = {6'h21, 26'h0450010};
  localparam logic [31:0] I_LW  = {6'h23, 26'h0220100};
  localparam logic [31:0] I_LBU = {6'h24, 26'h0460004};
  localparam logic [31:0] I_LHU = {6'h25, 26'h0470008};
  localparam logic [31:0] I_SB  = {6'h28, 26'h0480001};
  localparam logic [31:0] I_SH  = {6'h29, 26'h0490002};
  localparam logic [31:0] I_SW  = {6'h2B, 26'h04A0004};
  localparam logic [31:0] I_ADD = 32'h0043_0820;
  localparam logic [31:0] I_NOP = 32'h0062_2020;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ex_z, ex_rt, ex_ir, ex_hi, ex_lo;
  logic [1:0]  condition;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, misalign, bus_err;
  logic [31:0] reg_Z, reg_D, reg_IR, reg_HI, reg_LO;

  mem_access #(.TIMEOUT(TIMEOUT), .IR_BUBBLE(BUB)) dut (
    .clk(clk), .rst(rst),
    .ex_z(ex_z), .ex_rt(ex_rt), .ex_ir(ex_ir), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .condition(condition),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_stall(mem_stall), .misalign(misalign), .bus_err(bus_err),
    .reg_Z(reg_Z), .reg_D(reg_D), .reg_IR(reg_IR), .reg_HI(reg_HI), .reg_LO(reg_LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir, z, rt, hi, lo, rdata;
    int          k;       // WAIT cycle carrying the ack; 0 = never acked
    int          hold;    // extra STALL cycles before the retiring FLOW
    bit          req, we;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          stalls;
    logic [31:0] d, irx;
    bit          mis, berr;
  } vec_t;

  int          n_err = 0;
  int          n_chk = 0;
  logic [31:0] prev_ir;
  vec_t        tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ir, z, rt, rdata, input int k,
                              input bit req, we, input logic [3:0] be,
                              input logic [31:0] wdata, input int stalls,
                              input logic [31:0] d, irx, input bit mis, berr);
    vec_t t;
    t.ir = ir; t.z = z; t.rt = rt; t.rdata = rdata; t.k = k;
    t.hi = $urandom; t.lo = $urandom; t.hold = 1;
    t.req = req; t.we = we; t.be = be; t.wdata = wdata; t.stalls = stalls;
    t.d = d; t.irx = irx; t.mis = mis; t.berr = berr;
    return t;
  endfunction

  // Reference: access size/sign from the opcode, then plain byte arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t   t = v;
    int     size = 0, off, nb;
    bit     ld = 0, st = 0, sgn = 0;
    longint val;
    case (v.ir[31:26])
      6'h20: begin size = 1; ld = 1; sgn = 1; end
      6'h21: begin size = 2; ld = 1; sgn = 1; end
      6'h23: begin size = 4; ld = 1; end
      6'h24: begin size = 1; ld = 1; end
      6'h25: begin size = 2; ld = 1; end
      6'h28: begin size = 1; st = 1; end
      6'h29: begin size = 2; st = 1; end
      6'h2B: begin size = 4; st = 1; end
      default: size = 0;
    endcase
    off = int'(v.z[1:0]);
    t.req = 0; t.we = 0; t.be = 4'h0; t.wdata = 32'h0; t.stalls = 0;
    t.d = 32'h0; t.irx = v.ir; t.mis = 0; t.berr = 0;
    if (size != 0 && (off % size) != 0) begin
      t.mis = 1;
      t.irx = BUB;
    end else if (size != 0) begin
      t.req = 1;
      t.we  = st;
      t.be  = 4'(((1 << size) - 1) << off);
      for (int i = 0; i < 4; i++) t.wdata[8*i +: 8] = v.rt[8*(i % size) +: 8];
      if (v.k == 0) begin
        t.stalls = TIMEOUT + 1;
        t.berr   = 1;
        t.irx    = BUB;
      end else begin
        t.stalls = v.k + 1;
        if (ld) begin
          nb  = 8 * size;
          val = {32'h0, v.rdata};
          val = (val >> (8 * off)) & ((64'sd1 <<< nb) - 1);
          if (sgn && val >= (64'sd1 <<< (nb - 1))) val = val - (64'sd1 <<< nb);
          t.d = val[31:0];
        end
      end
    end
    return t;
  endfunction

  task automatic run_vec(input vec_t v);
    int          stalls = 0;
    logic [31:0] nz;
    ex_ir = v.ir; ex_z = v.z; ex_rt = v.rt; ex_hi = v.hi; ex_lo = v.lo;
    condition = C_STALL; dmem_ack = 1'b0; dmem_rdata = $urandom;
    #1;
    chk("req", 32'(dmem_req), 32'(v.req));
    chk("we", 32'(dmem_we), 32'(v.we));
    chk("be", 32'(dmem_be), 32'(v.be));
    if (v.req) begin
      chk("wdata", dmem_wdata, v.wdata);
      chk("addr", dmem_addr, v.z & 32'hFFFF_FFFC);
    end
    while (mem_stall && stalls <= TIMEOUT + 2) begin
      stalls++;
      chk("hold_ir_stall", reg_IR, prev_ir);
      @(posedge clk); #1;
      dmem_ack   = (v.k != 0 && stalls == v.k);
      dmem_rdata = dmem_ack ? v.rdata : $urandom;
      #1;
    end
    chk("stall_cycles", 32'(stalls), 32'(v.stalls));
    chk("bus_err", 32'(bus_err), 32'(v.berr));
    dmem_ack = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      condition = C_STALL; dmem_ack = 1'b1; dmem_rdata = $urandom;
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      chk("hold_ir_done", reg_IR, prev_ir);
      chk("stall_done", 32'(mem_stall), 32'h0);
    end
    condition = C_FLOW;
    @(posedge clk); #1;
    condition = C_STALL;
    chk("reg_Z", reg_Z, v.z);
    chk("reg_D", reg_D, v.d);
    chk("reg_IR", reg_IR, v.irx);
    chk("reg_HI", reg_HI, v.hi);
    chk("reg_LO", reg_LO, v.lo);
    chk("misalign", 32'(misalign), 32'(v.mis));
    nz = $urandom;
    ex_ir = I_NOP; ex_z = nz; ex_hi = $urandom; ex_lo = $urandom; condition = C_FLOW;
    #1;
    chk("nop_stall", 32'(mem_stall), 32'h0);
    @(posedge clk); #1;
    chk("nop_ir", reg_IR, I_NOP);
    chk("nop_z", reg_Z, nz);
    chk("misalign_pulse", 32'(misalign), 32'h0);
    chk("bus_err_pulse", 32'(bus_err), 32'h0);
    prev_ir = I_NOP;
  endtask

  initial begin
    vec_t        v;
    logic [31:0] r;
    logic [5:0]  ops [13];
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B,
            6'h00, 6'h08, 6'h0F, 6'h22, 6'h2A};

    tbl[0]  = mk(I_LW,  32'h100, 32'h1111_1111, 32'hDEAD_BEEF, 3, 1, 0, 4'hF, 32'h1111_1111, 4, 32'hDEAD_BEEF, I_LW, 0, 0);
    tbl[1]  = mk(I_LB,  32'h103, 32'h0000_00A5, 32'h80FF_FF7F, 1, 1, 0, 4'h8, 32'hA5A5_A5A5, 2, 32'hFFFF_FF80, I_LB, 0, 0);
    tbl[2]  = mk(I_LBU, 32'h103, 32'h0000_00A5, 32'h80FF_FF7F, 2, 1, 0, 4'h8, 32'hA5A5_A5A5, 3, 32'h0000_0080, I_LBU, 0, 0);
    tbl[3]  = mk(I_SH,  32'h202, 32'h1234_ABCD, 32'hFFFF_FFFF, 2, 1, 1, 4'hC, 32'hABCD_ABCD, 3, 32'h0, I_SH, 0, 0);
    tbl[4]  = mk(I_LW,  32'h101, 32'h0,         32'h5555_5555, 1, 0, 0, 4'h0, 32'h0, 0, 32'h0, BUB, 1, 0);
    tbl[5]  = mk(I_LW,  32'h300, 32'h7777_0000, 32'h0,         0, 1, 0, 4'hF, 32'h7777_0000, 17, 32'h0, BUB, 0, 1);
    tbl[6]  = mk(I_ADD, 32'h1234_5678, 32'h9, 32'h0,           0, 0, 0, 4'h0, 32'h0, 0, 32'h0, I_ADD, 0, 0);
    tbl[7]  = mk(I_LH,  32'h102, 32'h0000_3C3C, 32'h8001_0000, 4, 1, 0, 4'hC, 32'h3C3C_3C3C, 5, 32'hFFFF_8001, I_LH, 0, 0);
    tbl[8]  = mk(I_LHU, 32'h102, 32'h0000_3C3C, 32'h8001_0000, 1, 1, 0, 4'hC, 32'h3C3C_3C3C, 2, 32'h0000_8001, I_LHU, 0, 0);
    tbl[9]  = mk(I_SB,  32'h201, 32'h0000_0055, 32'h0,         1, 1, 1, 4'h2, 32'h5555_5555, 2, 32'h0, I_SB, 0, 0);
    tbl[10] = mk(I_SW,  32'h204, 32'hCAFE_F00D, 32'h0,         5, 1, 1, 4'hF, 32'hCAFE_F00D, 6, 32'h0, I_SW, 0, 0);
    tbl[11] = mk(I_SH,  32'h203, 32'h1234_5678, 32'h0,         1, 0, 0, 4'h0, 32'h0, 0, 32'h0, BUB, 1, 0);
    tbl[12] = mk(I_LH,  32'h100, 32'h0,         32'h1234_7FFE, 1, 1, 0, 4'h3, 32'h0, 2, 32'h0000_7FFE, I_LH, 0, 0);

    // Reset, with an aligned load already sitting on the inputs.
    rst = 1'b1; condition = C_FLOW;
    ex_ir = I_LW; ex_z = 32'h100; ex_rt = 32'h0; ex_hi = 32'h0; ex_lo = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #12;
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_we", 32'(dmem_we), 32'h0);
    chk("rst_be", 32'(dmem_be), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_Z", reg_Z, 32'h0);
    chk("rst_D", reg_D, 32'h0);
    chk("rst_IR", reg_IR, BUB);
    chk("rst_HI", reg_HI, 32'h0);
    chk("rst_LO", reg_LO, 32'h0);
    chk("rst_misalign", 32'(misalign), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    ex_ir = I_NOP; condition = C_STALL;
    rst = 1'b0;
    prev_ir = BUB;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) run_vec(tbl[i]);

    // Squash while waiting; the late ack must not revive the transaction.
    ex_ir = I_LW; ex_z = 32'h400; ex_rt = $urandom; condition = C_STALL;
    #1;
    chk("zero_req_idle", 32'(dmem_req), 32'h1);
    @(posedge clk); #1;
    chk("zero_req_wait", 32'(dmem_req), 32'h1);
    condition = C_ZERO;
    @(posedge clk); #1;
    ex_ir = I_NOP; condition = C_STALL;
    #1;
    chk("zero_req", 32'(dmem_req), 32'h0);
    chk("zero_stall", 32'(mem_stall), 32'h0);
    chk("zero_Z", reg_Z, 32'h0);
    chk("zero_D", reg_D, 32'h0);
    chk("zero_IR", reg_IR, BUB);
    chk("zero_HI", reg_HI, 32'h0);
    chk("zero_LO", reg_LO, 32'h0);
    dmem_ack = 1'b1; dmem_rdata = $urandom;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    #1;
    chk("zero_late_req", 32'(dmem_req), 32'h0);
    chk("zero_late_stall", 32'(mem_stall), 32'h0);
    chk("zero_late_IR", reg_IR, BUB);
    chk("zero_late_bus_err", 32'(bus_err), 32'h0);
    prev_ir = BUB;
    run_vec(tbl[0]);

    // Reset while waiting drops req at once.
    ex_ir = I_LW; ex_z = 32'h500; ex_rt = $urandom; condition = C_STALL;
    #1;
    @(posedge clk); #1;
    chk("rstw_req_wait", 32'(dmem_req), 32'h1);
    rst = 1'b1;
    #1;
    chk("rstw_req", 32'(dmem_req), 32'h0);
    chk("rstw_stall", 32'(mem_stall), 32'h0);
    chk("rstw_IR", reg_IR, BUB);
    chk("rstw_Z", reg_Z, 32'h0);
    ex_ir = I_NOP;
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    dmem_ack = 1'b1; dmem_rdata = $urandom;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    #1;
    chk("rstw_late_req", 32'(dmem_req), 32'h0);
    chk("rstw_late_stall", 32'(mem_stall), 32'h0);
    chk("rstw_late_IR", reg_IR, BUB);
    chk("rstw_late_D", reg_D, 32'h0);
    prev_ir = BUB;
    run_vec(tbl[3]);

    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      v.ir    = {ops[$urandom_range(0, 12)], r[25:0]};
      v.z     = $urandom;
      v.rt    = $urandom;
      v.hi    = $urandom;
      v.lo    = $urandom;
      v.rdata = $urandom;
      v.k     = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      v.hold  = int'($urandom_range(0, 2));
      run_vec(model(v));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
